// File: rtl/mode4_sum_feeder.sv
// Control and data feeder for the mode4 adder tree: registers element pairs onto the
// tree inputs, strobes each pipeline stage exactly once per pair and returns the vector sum.
module mode4_sum_feeder #(
    parameter int DATAWIDTH = 16,
    parameter int LEN_W     = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     length,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data0,
    input  logic [DATAWIDTH-1:0] in_data1,
    output logic [DATAWIDTH-1:0] tree_inp0,
    output logic [DATAWIDTH-1:0] tree_inp1,
    output logic                 mode4_stage1_run,
    output logic                 mode4_stage0_run,
    output logic                 tree_clear,
    input  logic [DATAWIDTH-1:0] tree_outp,
    output logic                 busy,
    output logic [DATAWIDTH-1:0] sum_out,
    output logic                 sum_valid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [LEN_W:0]     CNT_ZERO = {(LEN_W+1){1'b0}};
    localparam logic [LEN_W:0]     CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [DATAWIDTH-1:0] FP_ZERO = {DATAWIDTH{1'b0}};

    state_t               state_r;
    state_t               state_next_s;
    logic [LEN_W:0]       pairs_left_r;
    logic                 odd_r;
    logic                 v1_r;
    logic                 v2_r;
    logic [DATAWIDTH-1:0] tree_inp0_r;
    logic [DATAWIDTH-1:0] tree_inp1_r;
    logic                 tree_clear_r;
    logic                 busy_r;
    logic [DATAWIDTH-1:0] sum_out_r;
    logic                 sum_valid_r;

    logic [LEN_W:0]       len_plus_one_s;
    logic [LEN_W:0]       pair_count_s;
    logic                 accept_s;
    logic                 last_pair_s;
    logic                 drain_done_s;

    // Odd-length vectors end with a half-pair; its missing element becomes +0.0.
    function automatic logic [DATAWIDTH-1:0] pad_odd(input logic [DATAWIDTH-1:0] data,
                                                     input logic zero_it);
        if (zero_it) begin
            return FP_ZERO;
        end else begin
            return data;
        end
    endfunction

    // One extra bit keeps (N+1) from wrapping at the largest length.
    assign len_plus_one_s = {1'b0, length} + CNT_ONE;
    assign pair_count_s   = {1'b0, len_plus_one_s[LEN_W:1]};

    assign in_ready     = (state_r == S_RUN) && (pairs_left_r != CNT_ZERO);
    assign accept_s     = in_valid && in_ready;
    assign last_pair_s  = (pairs_left_r == CNT_ONE);
    assign drain_done_s = (state_r == S_DRAIN) && !v1_r && !v2_r;

    // Next-state logic of the vector sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_next_s = S_CLEAR;
                else       state_next_s = S_IDLE;
            end
            S_CLEAR: begin
                if (pairs_left_r != CNT_ZERO) state_next_s = S_RUN;
                else                          state_next_s = S_DRAIN;
            end
            S_RUN: begin
                if (accept_s && last_pair_s) state_next_s = S_DRAIN;
                else                         state_next_s = S_RUN;
            end
            S_DRAIN: begin
                if (drain_done_s) state_next_s = S_DONE;
                else              state_next_s = S_DRAIN;
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Pair bookkeeping and stage strobes; v1/v2 follow each accept by one and two cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pairs_left_r <= CNT_ZERO;
            odd_r        <= 1'b0;
            v1_r         <= 1'b0;
            v2_r         <= 1'b0;
        end else begin
            if (state_r == S_IDLE && start) begin
                pairs_left_r <= pair_count_s;
                odd_r        <= length[0];
            end else if (accept_s) begin
                pairs_left_r <= pairs_left_r - CNT_ONE;
            end else begin
                pairs_left_r <= pairs_left_r;
            end
            v1_r <= accept_s;
            v2_r <= v1_r;
        end
    end

    // Registered datapath and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tree_inp0_r  <= FP_ZERO;
            tree_inp1_r  <= FP_ZERO;
            tree_clear_r <= 1'b0;
            busy_r       <= 1'b0;
            sum_out_r    <= FP_ZERO;
            sum_valid_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                tree_inp0_r <= in_data0;
                tree_inp1_r <= pad_odd(in_data1, odd_r && last_pair_s);
            end
            if (drain_done_s) begin
                sum_out_r <= tree_outp;
            end
            tree_clear_r <= (state_next_s == S_CLEAR);
            busy_r       <= (state_next_s != S_IDLE);
            sum_valid_r  <= (state_next_s == S_DONE);
        end
    end

    assign tree_inp0        = tree_inp0_r;
    assign tree_inp1        = tree_inp1_r;
    assign mode4_stage1_run = v1_r;
    assign mode4_stage0_run = v2_r;
    assign tree_clear       = tree_clear_r;
    assign busy             = busy_r;
    assign sum_out          = sum_out_r;
    assign sum_valid        = sum_valid_r;

endmodule

// File: tb/tb_mode4_sum_feeder.sv
// Scoreboard bench for mode4_sum_feeder: a real-valued adder-tree model closes the loop,
// the driver queues expected pairs and sums, and a monitor checks them as they appear.
module tb_mode4_sum_feeder;
    localparam int DW = 16;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] length = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data0 = '0;
    logic [DW-1:0] in_data1 = '0;
    logic [DW-1:0] tree_inp0, tree_inp1;
    logic          mode4_stage1_run, mode4_stage0_run, tree_clear;
    logic [DW-1:0] tree_outp;
    logic          busy;
    logic [DW-1:0] sum_out;
    logic          sum_valid;

    mode4_sum_feeder #(.DATAWIDTH(DW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .in_valid(in_valid), .in_ready(in_ready), .in_data0(in_data0), .in_data1(in_data1),
        .tree_inp0(tree_inp0), .tree_inp1(tree_inp1),
        .mode4_stage1_run(mode4_stage1_run), .mode4_stage0_run(mode4_stage0_run),
        .tree_clear(tree_clear), .tree_outp(tree_outp), .busy(busy),
        .sum_out(sum_out), .sum_valid(sum_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real from_fp16(input logic [15:0] h);
        real v;
        int  e;
        e = int'(h[14:10]);
        v = (e == 0) ? real'(h[9:0]) : 1024.0 + real'(h[9:0]);
        if (e == 0) e = 1;
        for (int i = 0; i < 25 - e; i++) v = v / 2.0;
        for (int i = 0; i < e - 25; i++) v = v * 2.0;
        return h[15] ? -v : v;
    endfunction

    // Positive normal values only, which is all this bench produces.
    function automatic logic [15:0] to_fp16(input real r);
        real x;
        int  e;
        int  m;
        if (r == 0.0) return 16'h0000;
        x = r;
        e = 15;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0) begin x = x * 2.0; e--; end
        m = $rtoi((x - 1.0) * 1024.0 + 0.5);
        if (m == 1024) begin m = 0; e++; end
        return {1'b0, e[4:0], m[9:0]};
    endfunction

    // Adder tree: stage1 forms the pair sum, stage0 adds it into the accumulator.
    real s1_val = 0.0;
    real acc_val = 0.0;
    always @(posedge clk) begin
        if (tree_clear) acc_val <= 0.0;
        else if (mode4_stage0_run) acc_val <= acc_val + s1_val;
        if (mode4_stage1_run) s1_val <= from_fp16(tree_inp0) + from_fp16(tree_inp1);
    end
    always_comb tree_outp = to_fp16(acc_val);

    typedef struct {
        logic [15:0] sum;
        int          cyc;
        int          pairs;
    } vexp_t;

    vexp_t       sum_q[$];
    logic [31:0] pair_q[$];
    logic [15:0] elems[0:1023];
    int          gaps[0:511];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: consumes expected pairs on every stage1 strobe and expected sums on sum_valid.
    initial begin
        int s1_cnt, s0_cnt, clr_cnt;
        logic prev_sv;
        logic [31:0] p;
        vexp_t e;
        s1_cnt = 0; s0_cnt = 0; clr_cnt = 0; prev_sv = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                s1_cnt = 0; s0_cnt = 0; clr_cnt = 0; prev_sv = 1'b0;
            end else begin
                if (mode4_stage1_run) s1_cnt++;
                if (mode4_stage0_run) s0_cnt++;
                if (tree_clear) clr_cnt++;
                if (mode4_stage1_run) begin
                    if (pair_q.size() == 0) begin
                        chk("unexpected_stage1", 64'(1), 64'(0));
                    end else begin
                        p = pair_q.pop_front();
                        chk("tree_pair", 64'({tree_inp0, tree_inp1}), 64'(p));
                    end
                end
                if (in_ready) chk("ready_while_busy", 64'(busy), 64'(1));
                if (prev_sv) chk("busy_after_done", 64'(busy), 64'(0));
                if (sum_valid) begin
                    if (sum_q.size() == 0) begin
                        chk("unexpected_sum_valid", 64'(1), 64'(0));
                    end else begin
                        e = sum_q.pop_front();
                        chk("sum_out", 64'(sum_out), 64'(e.sum));
                        chk("sum_latency", 64'(cyc), 64'(e.cyc));
                        chk("stage1_count", 64'(s1_cnt), 64'(e.pairs));
                        chk("stage0_count", 64'(s0_cnt), 64'(e.pairs));
                        chk("clear_count", 64'(clr_cnt), 64'(1));
                    end
                    s1_cnt = 0; s0_cnt = 0; clr_cnt = 0;
                end
                prev_sv = sum_valid;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_strobes"}, 64'({mode4_stage1_run, mode4_stage0_run, tree_clear, sum_valid}), 64'(0));
        chk({tag, "_tree_inp"}, 64'({tree_inp0, tree_inp1}), 64'(0));
        chk({tag, "_sum_out"}, 64'(sum_out), 64'(0));
    endtask

    // Drives one vector; abort_at >= 0 resets the block asynchronously before that pair.
    task automatic run_vector(input int n, input bit poke_start, input int abort_at);
        int    npairs, bound, acc_cyc;
        real   ref_sum;
        vexp_t e;
        bit    ok;
        npairs = (n + 1) / 2;
        ref_sum = 0.0;
        for (int i = 0; i < n; i++) ref_sum += from_fp16(elems[i]);
        e.sum = to_fp16(ref_sum);
        e.pairs = npairs;
        e.cyc = cyc + 3;
        acc_cyc = 0;
        start = 1'b1;
        length = n[LW-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < npairs; k++) begin
            if (k == abort_at) begin
                #3;
                start = 1'b1;
                length = 10'd3;
                #1;
                reset = 1'b0;
                #1;
                check_idle_outputs("abort");
                pair_q.delete();
                sum_q.delete();
                in_valid = 1'b0;
                start = 1'b0;
                @(posedge clk); #1;
                chk("abort_held_busy", 64'(busy), 64'(0));
                reset = 1'b1;
                @(posedge clk); #1;
                return;
            end
            in_valid = 1'b0;
            for (int g = 0; g < gaps[k]; g++) begin
                if (poke_start) begin start = 1'b1; length = 10'd5; end
                @(posedge clk); #1;
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data0 = elems[2*k];
            in_data1 = elems[2*k+1];
            ok = 1'b0;
            bound = 0;
            while (!ok && bound < 100) begin
                @(negedge clk);
                ok = in_ready;
                acc_cyc = cyc;
                @(posedge clk); #1;
                bound++;
            end
            if (!ok) begin
                chk("accept_timeout", 64'(0), 64'(1));
                in_valid = 1'b0;
                return;
            end
            pair_q.push_back({elems[2*k], (2*k+1 < n) ? elems[2*k+1] : 16'h0000});
        end
        in_valid = 1'b0;
        if (npairs > 0) e.cyc = acc_cyc + 4;
        sum_q.push_back(e);
        bound = 0;
        while (sum_q.size() != 0 && bound < 60) begin
            @(posedge clk);
            bound++;
        end
        chk("sum_pending", 64'(sum_q.size()), 64'(0));
        chk("pairs_pending", 64'(pair_q.size()), 64'(0));
        sum_q.delete();
        pair_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic fill(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
        for (int i = 0; i < 1024; i++) elems[i] = 16'h0000;
        for (int i = 0; i < 512; i++) gaps[i] = 0;
        elems[0] = a; elems[1] = b; elems[2] = c; elems[3] = d;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        fill(16'h3C00, 16'h4000, 16'h4200, 16'h4400);
        run_vector(4, 1'b0, -1);
        fill(16'h3C00, 16'h4000, 16'h4200, 16'h7BFF);
        run_vector(3, 1'b0, -1);
        fill(16'h3C00, 16'h4000, 16'h4200, 16'h4400);
        gaps[0] = 0; gaps[1] = 3;
        run_vector(4, 1'b1, -1);
        fill(16'h3C00, 16'h4000, 16'h4200, 16'h4400);
        run_vector(4, 1'b0, -1);
        fill(16'h3C00, 16'h3C00, 16'h7BFF, 16'h7BFF);
        run_vector(2, 1'b0, -1);
        fill(16'h7BFF, 16'h7BFF, 16'h0000, 16'h0000);
        run_vector(0, 1'b0, -1);
        fill(16'h3C00, 16'h4000, 16'h4200, 16'h4400);
        gaps[1] = 2;
        run_vector(8, 1'b0, 2);
        fill(16'h4200, 16'h3C00, 16'h0000, 16'h0000);
        run_vector(2, 1'b0, -1);
        fill(16'h3C00, 16'h0000, 16'h0000, 16'h0000);
        elems[1022] = 16'h4000;
        elems[1023] = 16'h7BFF;
        run_vector(1023, 1'b0, -1);

        for (int v = 0; v < 15; v++) begin
            n = $urandom_range(0, 20);
            for (int i = 0; i < 64; i++) elems[i] = to_fp16(real'($urandom_range(0, 15)));
            for (int i = 0; i < 32; i++) gaps[i] = $urandom_range(0, 2);
            run_vector(n, 1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
